// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// State encoding and header field positions.
package prog_loader_pkg;

    localparam logic [1:0] HDR  = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    localparam int CNT_MSB  = 15;
    localparam int CNT_LSB  = 8;
    localparam int BASE_LSB = 0;

endpackage

// File: rtl/prog_loader_if.sv
// Program stream valid/ready handshake.
// The producer is the master, the loader is the slave.
interface prog_loader_if #(
    parameter int DATA_WIDTH = 16
);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/prog_loader_register.sv
// Loadable incrementing register used as the load address counter.
// Load has priority over increment; the increment wraps.
module prog_loader_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             inc,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (inc) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams a program into memory while the
// core is held in reset, then hands the memory port to the core.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prog_loader_if.slave          s,
    input  logic                  reload,
    output logic                  cpu_rst_n,
    input  logic                  cpu_mem_we,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
    input  logic [DATA_WIDTH-1:0] cpu_mem_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  running,
    output logic [7:0]            words_left
);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  hs;
    logic                  ld;
    logic                  wr;
    logic [7:0]            hdr_n;
    logic [ADDR_WIDTH-1:0] hdr_base;
    logic                  unused_hdr;

    assign s.in_ready = (state != RUN);
    assign hs         = s.in_valid && s.in_ready;
    assign ld         = hs && (state == HDR);
    assign wr         = hs && (state == DATA);

    assign hdr_n      = s.in_data[CNT_MSB:CNT_LSB];
    assign hdr_base   = s.in_data[BASE_LSB +: ADDR_WIDTH];
    // Header bits between count and base carry no meaning.
    assign unused_hdr = ^s.in_data;

    prog_loader_register #(
        .WIDTH (ADDR_WIDTH)
    ) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld),
        .inc   (wr),
        .d     (hdr_base),
        .q     (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HDR;
            words_left <= 8'd0;
            cpu_rst_n  <= 1'b0;
            running    <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == HDR): begin
                    if (hs) begin
                        if (hdr_n != 8'd0) begin
                            state      <= DATA;
                            words_left <= hdr_n;
                        end else begin
                            state     <= RUN;
                            cpu_rst_n <= 1'b1;
                            running   <= 1'b1;
                        end
                    end
                end
                (state == DATA): begin
                    if (hs) begin
                        words_left <= words_left - 8'd1;
                        if (words_left == 8'd1) begin
                            state     <= RUN;
                            cpu_rst_n <= 1'b1;
                            running   <= 1'b1;
                        end
                    end
                end
                (state == RUN): begin
                    if (reload) begin
                        state     <= HDR;
                        cpu_rst_n <= 1'b0;
                        running   <= 1'b0;
                    end
                end
                default: begin
                    state      <= HDR;
                    words_left <= 8'd0;
                    cpu_rst_n  <= 1'b0;
                    running    <= 1'b0;
                end
            endcase
        end
    end

    // Core owns the port only in RUN; otherwise idle reads sit at the counter.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = cnt;
        mem_data = '0;
        if (state == RUN) begin
            mem_we   = cpu_mem_we;
            mem_addr = cpu_mem_addr;
            mem_data = cpu_mem_data;
        end else if (wr) begin
            mem_we   = 1'b1;
            mem_data = s.in_data;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Scenario tasks run in sequence from one initial block.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reload;
    logic        cpu_rst_n;
    logic        cpu_mem_we;
    logic [5:0]  cpu_mem_addr;
    logic [15:0] cpu_mem_data;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;
    logic        running;
    logic [7:0]  words_left;

    int n_tests = 0;
    int n_fail  = 0;

    prog_loader_if #(.DATA_WIDTH(16)) s_if ();

    prog_loader #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s            (s_if),
        .reload       (reload),
        .cpu_rst_n    (cpu_rst_n),
        .cpu_mem_we   (cpu_mem_we),
        .cpu_mem_addr (cpu_mem_addr),
        .cpu_mem_data (cpu_mem_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .running      (running),
        .words_left   (words_left)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_hdr;
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        reload = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_data = 16'h0;
        cpu_mem_we = 1'b0;
        cpu_mem_addr = 6'd0;
        cpu_mem_data = 16'h0;
        tick();
        tick();
        n_tests++;
        if ({cpu_rst_n, running, words_left} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got rst=%b run=%b wl=%0d want 0 0 0",
                     cpu_rst_n, running, words_left);
        end
        n_tests++;
        if (s_if.in_ready !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: got rdy=%b we=%b want 1 0",
                     s_if.in_ready, mem_we);
        end
        n_tests++;
        if (mem_addr !== 6'd0 || mem_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr=%0d data=%h want 0 0000",
                     mem_addr, mem_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic [15:0] words [3];
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        s_if.in_valid = 1'b1;
        s_if.in_data = 16'h0308;
        #1;
        n_tests++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hdr_we: got %b want 0", mem_we);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            s_if.in_data = words[i];
            #1;
            n_tests++;
            if (mem_we !== 1'b1 || mem_addr !== 6'(8 + i) ||
                mem_data !== words[i]) begin
                n_fail++;
                $display("FAIL basic_wr%0d: got we=%b a=%0d d=%h want 1 %0d %h",
                         i, mem_we, mem_addr, mem_data, 8 + i, words[i]);
            end
            n_tests++;
            if (words_left !== 8'(3 - i) || cpu_rst_n !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_wl%0d: got wl=%0d rst=%b want %0d 0",
                         i, words_left, cpu_rst_n, 3 - i);
            end
            tick();
        end
        s_if.in_valid = 1'b0;
        #1;
        n_tests++;
        if (cpu_rst_n !== 1'b1 || running !== 1'b1 ||
            s_if.in_ready !== 1'b0 || words_left !== 8'd0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_run: got rst=%b run=%b rdy=%b wl=%0d we=%b want 1 1 0 0 0",
                     cpu_rst_n, running, s_if.in_ready, words_left, mem_we);
        end
    endtask

    task automatic test_reload;
        cpu_mem_we = 1'b1;
        cpu_mem_addr = 6'd5;
        cpu_mem_data = 16'hBEEF;
        reload = 1'b1;
        #1;
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd5 || mem_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL pass_thru: got we=%b a=%0d d=%h want 1 5 beef",
                     mem_we, mem_addr, mem_data);
        end
        tick();
        reload = 1'b0;
        #1;
        n_tests++;
        if (cpu_rst_n !== 1'b0 || running !== 1'b0 || s_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_state: got rst=%b run=%b rdy=%b want 0 0 1",
                     cpu_rst_n, running, s_if.in_ready);
        end
        n_tests++;
        if (mem_we !== 1'b0 || mem_addr !== 6'd11 || mem_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reload_block: got we=%b a=%0d d=%h want 0 11 0000",
                     mem_we, mem_addr, mem_data);
        end
        cpu_mem_we = 1'b0;
    endtask

    task automatic test_wrap;
        s_if.in_valid = 1'b1;
        s_if.in_data = 16'h023F;
        #1;
        n_tests++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_hdr_we: got %b want 0", mem_we);
        end
        tick();
        s_if.in_data = 16'hAAAA;
        #1;
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd63 || mem_data !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL wrap_63: got we=%b a=%0d d=%h want 1 63 aaaa",
                     mem_we, mem_addr, mem_data);
        end
        tick();
        s_if.in_data = 16'hBBBB;
        #1;
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_data !== 16'hBBBB ||
            words_left !== 8'd1) begin
            n_fail++;
            $display("FAIL wrap_0: got we=%b a=%0d d=%h wl=%0d want 1 0 bbbb 1",
                     mem_we, mem_addr, mem_data, words_left);
        end
        tick();
        s_if.in_valid = 1'b0;
        #1;
        n_tests++;
        if (running !== 1'b1 || cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_run: got run=%b rst=%b want 1 1", running, cpu_rst_n);
        end
    endtask

    task automatic test_zero;
        s_if.in_valid = 1'b1;
        s_if.in_data = 16'h0000;
        #1;
        n_tests++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_we: got %b want 0", mem_we);
        end
        tick();
        s_if.in_valid = 1'b0;
        #1;
        n_tests++;
        if (cpu_rst_n !== 1'b1 || running !== 1'b1 ||
            words_left !== 8'd0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_run: got rst=%b run=%b wl=%0d we=%b want 1 1 0 0",
                     cpu_rst_n, running, words_left, mem_we);
        end
    endtask

    task automatic test_gaps;
        int k;
        int writes;
        logic v;
        k = 0;
        writes = 0;
        s_if.in_valid = 1'b1;
        s_if.in_data = 16'h0410;
        tick();
        for (int c = 0; c < 8; c++) begin
            v = (c % 2) == 1;
            s_if.in_valid = v;
            s_if.in_data = 16'h4000 + 16'(c);
            #1;
            if (mem_we === 1'b1) writes++;
            n_tests++;
            if (mem_we !== v || words_left !== 8'(4 - k) ||
                (v && (mem_addr !== 6'(16 + k) || mem_data !== 16'h4000 + 16'(c)))) begin
                n_fail++;
                $display("FAIL gaps_c%0d: got we=%b a=%0d wl=%0d want %b %0d %0d",
                         c, mem_we, mem_addr, words_left, v, 16 + k, 4 - k);
            end
            if (v) k++;
            tick();
        end
        s_if.in_valid = 1'b0;
        #1;
        n_tests++;
        if (writes !== 4 || words_left !== 8'd0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_end: got writes=%0d wl=%0d run=%b want 4 0 1",
                     writes, words_left, running);
        end
    endtask

    task automatic test_reset_mid;
        s_if.in_valid = 1'b1;
        s_if.in_data = 16'h0520;
        tick();
        s_if.in_data = 16'h7777;
        tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (cpu_rst_n !== 1'b0 || mem_we !== 1'b0 || s_if.in_ready !== 1'b1 ||
            words_left !== 8'd0 || mem_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_rst: got rst=%b we=%b rdy=%b wl=%0d a=%0d want 0 0 1 0 0",
                     cpu_rst_n, mem_we, s_if.in_ready, words_left, mem_addr);
        end
        tick();
        rst_n = 1'b1;
        s_if.in_data = 16'h9999;
        #1;
        n_tests++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_hdr_we: got %b want 0", mem_we);
        end
        tick();
        s_if.in_valid = 1'b0;
        #1;
        n_tests++;
        if (words_left !== 8'h99 || mem_addr !== 6'h19 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_hdr: got wl=%h a=%h run=%b want 99 19 0",
                     words_left, mem_addr, running);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_wrap();
        go_hdr();
        test_zero();
        go_hdr();
        test_gaps();
        go_hdr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
